// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_BE_W   = 32;

  // Arbiter control states for the host side; the VLSU path is stateless.
  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    RD_WAIT,
    RESP
  } arb_state_e;

  // One buffered host request. Field widths follow the default constants,
  // so a wider configuration needs these constants raised to match.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] address;
    logic [DEF_BE_W-1:0]   byteena;
    logic [DEF_DATA_W-1:0] writeData;
  } host_req_t;

endpackage

// File: rtl/rd_latency_pipe.sv
// Valid shift register matching the dmem read latency; capture is high in
// the cycle the RAM presents data for the read issued LATENCY cycles earlier.
module rd_latency_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic capture
);

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;

  // Shift the issue marker one stage per cycle.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Stage registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign capture = vld_q[LATENCY-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the dmem port between the VLSU (absolute priority, zero added
// latency) and a single-entry buffered host loader port.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BE_W         = DEF_BE_W,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vlsu_rden,
  input  logic              vlsu_wren,
  input  logic [ADDR_W-1:0] vlsu_address,
  input  logic [BE_W-1:0]   vlsu_byteena,
  input  logic [DATA_W-1:0] vlsu_writeData,
  output logic [DATA_W-1:0] vlsu_readData,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [BE_W-1:0]   host_byteena,
  input  logic [DATA_W-1:0] host_writeData,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_readData,
  output logic              host_starved,
  output logic              rden,
  output logic              wren,
  output logic [ADDR_W-1:0] ip_address,
  output logic [BE_W-1:0]   byteena,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  host_req_t         hold_q, hold_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic vlsu_active;
  logic host_issue;
  logic rd_issue;
  logic rd_capture;

  // The host only gets the port when the VLSU leaves it unused.
  assign vlsu_active = vlsu_rden | vlsu_wren;
  assign host_issue  = (state_q == PENDING) && !vlsu_active;
  assign rd_issue    = host_issue && !hold_q.we;

  rd_latency_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .issue   (rd_issue),
    .capture (rd_capture)
  );

  // Next-state: accept, wait for a free slot, await read data, respond.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (host_valid) begin
          hold_d.we        = host_we;
          hold_d.address   = host_address;
          hold_d.byteena   = host_byteena;
          hold_d.writeData = host_writeData;
          state_d          = PENDING;
        end
      end
      PENDING: begin
        if (host_issue) begin
          starve_d = '0;
          state_d  = hold_q.we ? IDLE : RD_WAIT;
        end else if (starve_q != STARVE_MAX) begin
          starve_d = starve_q + 1'b1;
        end
      end
      RD_WAIT: begin
        if (rd_capture) begin
          rdata_d = readData;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, holding register, starve counter and host read result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      starve_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
    end
  end

  // dmem mux: VLSU passes straight through except on a host issue cycle.
  always_comb begin
    rden       = vlsu_rden;
    wren       = vlsu_wren;
    ip_address = vlsu_address;
    byteena    = vlsu_byteena;
    writeData  = vlsu_writeData;
    if (host_issue) begin
      rden       = !hold_q.we;
      wren       = hold_q.we;
      ip_address = hold_q.address;
      byteena    = hold_q.we ? hold_q.byteena : '1;
      writeData  = hold_q.writeData;
    end
  end

  assign vlsu_readData = readData;
  assign host_ready    = (state_q == IDLE);
  assign host_rvalid   = (state_q == RESP);
  assign host_readData = rdata_q;
  assign host_starved  = (starve_q == STARVE_MAX);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 1-cycle-latency dmem model.
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 256;
  localparam int BE_W   = 32;

  logic              clk;
  logic              reset;
  logic              vlsu_rden, vlsu_wren;
  logic [ADDR_W-1:0] vlsu_address;
  logic [BE_W-1:0]   vlsu_byteena;
  logic [DATA_W-1:0] vlsu_writeData;
  logic [DATA_W-1:0] vlsu_readData;
  logic              host_valid, host_ready, host_we;
  logic [ADDR_W-1:0] host_address;
  logic [BE_W-1:0]   host_byteena;
  logic [DATA_W-1:0] host_writeData;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_readData;
  logic              host_starved;
  logic              rden, wren;
  logic [ADDR_W-1:0] ip_address;
  logic [BE_W-1:0]   byteena;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;

  int n_cmp = 0;
  int n_err = 0;
  int wren_cnt = 0;

  logic [DATA_W-1:0] mem [16];

  localparam logic [DATA_W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_D0 = {32{8'h11}};
  localparam logic [DATA_W-1:0] PAT_D1 = {32{8'h22}};
  localparam logic [DATA_W-1:0] PAT_C3 = {32{8'hC3}};

  dmem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .BE_W         (BE_W),
    .READ_LATENCY (1),
    .STARVE_LIMIT (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .vlsu_rden      (vlsu_rden),
    .vlsu_wren      (vlsu_wren),
    .vlsu_address   (vlsu_address),
    .vlsu_byteena   (vlsu_byteena),
    .vlsu_writeData (vlsu_writeData),
    .vlsu_readData  (vlsu_readData),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_we        (host_we),
    .host_address   (host_address),
    .host_byteena   (host_byteena),
    .host_writeData (host_writeData),
    .host_rvalid    (host_rvalid),
    .host_readData  (host_readData),
    .host_starved   (host_starved),
    .rden           (rden),
    .wren           (wren),
    .ip_address     (ip_address),
    .byteena        (byteena),
    .writeData      (writeData),
    .readData       (readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_v,
                                                 input logic [DATA_W-1:0] new_v,
                                                 input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // dmem model: registered read, byte-enabled write, 16 lines.
  always @(posedge clk) begin
    if (wren) mem[ip_address[3:0]] <= be_merge(mem[ip_address[3:0]], writeData, byteena);
    if (rden) readData <= mem[ip_address[3:0]];
    if (wren) wren_cnt <= wren_cnt + 1;
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic vlsu_idle();
    vlsu_rden = 0; vlsu_wren = 0; vlsu_address = '0; vlsu_byteena = '0; vlsu_writeData = '0;
  endtask

  task automatic vlsu_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    vlsu_rden = 0; vlsu_wren = 1; vlsu_address = a; vlsu_byteena = be; vlsu_writeData = d;
  endtask

  task automatic vlsu_rd(input logic [ADDR_W-1:0] a);
    vlsu_rden = 1; vlsu_wren = 0; vlsu_address = a; vlsu_byteena = '1; vlsu_writeData = '0;
  endtask

  task automatic host_idle();
    host_valid = 0; host_we = 0; host_address = '0; host_byteena = '0; host_writeData = '0;
  endtask

  task automatic host_req(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [BE_W-1:0] be);
    host_valid = 1; host_we = we; host_address = a; host_byteena = be; host_writeData = d;
    $display("txn host %s addr %0d", we ? "write" : "read", a);
  endtask

  initial begin
    int   base;
    logic seen;
    logic [7:0] pb;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    readData = '0;
    reset = 1'b0;
    vlsu_idle();
    host_idle();
    repeat (2) tick();
    reset = 1'b1;
    settle();
    chk("rst_ready", host_ready, 1);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_readData, 0);
    chk("rst_starved", host_starved, 0);
    chk("rst_strobes", {rden, wren}, 0);

    // Host write then read-back of addr 5.
    host_req(1, 5, PAT_A5, '1); settle();
    chk("wr_accept_ready", host_ready, 1);
    chk("wr_no_bypass", wren, 0);
    tick(); host_idle(); settle();
    chk("wr_wren", wren, 1);
    chk("wr_addr", ip_address, 5);
    chk("wr_data", writeData, PAT_A5);
    chk("wr_ready_low", host_ready, 0);
    tick(); settle();
    chk("wr_ready_back", host_ready, 1);
    chk("wr_single_pulse", wren, 0);
    host_req(0, 5, '0, '0); settle();
    tick(); host_idle(); settle();
    chk("rd_rden", rden, 1);
    chk("rd_addr", ip_address, 5);
    chk("rd_be", byteena, {BE_W{1'b1}});
    tick(); settle();
    chk("rd_no_early_rvalid", host_rvalid, 0);
    tick(); settle();
    chk("rd_rvalid", host_rvalid, 1);
    chk("rd_data", host_readData, PAT_A5);
    tick(); settle();
    chk("rd_rvalid_once", host_rvalid, 0);
    chk("rd_ready_back", host_ready, 1);

    // VLSU priority over a pending host read.
    host_req(0, 5, '0, '0); settle();
    tick(); host_idle(); vlsu_wr(0, PAT_D0, 32'hFFFF0000); settle();
    chk("pri0_wren", wren, 1);
    chk("pri0_addr", ip_address, 0);
    chk("pri0_data", writeData, PAT_D0);
    chk("pri0_be", byteena, 32'hFFFF0000);
    chk("pri0_rden", rden, 0);
    tick(); vlsu_wr(1, PAT_D1, 32'h0000FFFF); settle();
    chk("pri1_addr", ip_address, 1);
    chk("pri1_data", writeData, PAT_D1);
    chk("pri1_be", byteena, 32'h0000FFFF);
    tick(); vlsu_idle(); settle();
    chk("pri_issue_rden", rden, 1);
    chk("pri_issue_addr", ip_address, 5);
    tick(); settle();
    tick(); settle();
    chk("pri_rvalid", host_rvalid, 1);
    chk("pri_data", host_readData, PAT_A5);
    tick();

    // Interleave: VLSU reads addr 2 while the host read is in RD_WAIT.
    vlsu_wr(2, PAT_C3, '1); settle();
    chk("il_pre_wren", wren, 1);
    tick(); vlsu_idle(); host_req(0, 5, '0, '0); settle();
    tick(); host_idle(); settle();
    chk("il_issue_addr", ip_address, 5);
    tick(); vlsu_rd(2); settle();
    chk("il_vlsu_rden", rden, 1);
    chk("il_vlsu_addr", ip_address, 2);
    chk("il_bus_host_line", vlsu_readData, PAT_A5);
    tick(); vlsu_idle(); settle();
    chk("il_rvalid", host_rvalid, 1);
    chk("il_host_data", host_readData, PAT_A5);
    chk("il_vlsu_data", vlsu_readData, PAT_C3);
    tick();

    // Starvation: VLSU busy 10 cycles with a host read of addr 2 pending.
    host_req(0, 2, '0, '0); settle();
    tick(); host_idle();
    for (int k = 1; k <= 10; k++) begin
      vlsu_rd(0); settle();
      if (k == 3) chk("st_vlsu_owns", {rden, ip_address}, {1'b1, 14'd0});
      if (k == 4) chk("st_low_at4", host_starved, 0);
      if (k == 5) chk("st_high_at5", host_starved, 1);
      if (k == 10) chk("st_hold_at10", host_starved, 1);
      tick();
    end
    vlsu_idle(); settle();
    chk("st_issue", {rden, ip_address}, {1'b1, 14'd2});
    tick(); settle();
    chk("st_cleared", host_starved, 0);
    tick(); settle();
    chk("st_rvalid", host_rvalid, 1);
    chk("st_data", host_readData, PAT_C3);
    tick();

    // Reset while a host read is in RD_WAIT.
    host_req(0, 5, '0, '0); settle();
    tick(); host_idle(); settle();
    tick(); reset = 1'b0; settle();
    tick(); reset = 1'b1; settle();
    chk("rstm_ready", host_ready, 1);
    chk("rstm_rvalid", host_rvalid, 0);
    chk("rstm_strobes", {rden, wren}, 0);
    chk("rstm_rdata", host_readData, 0);
    seen = 1'b0;
    repeat (4) begin
      tick(); settle();
      if (host_rvalid) seen = 1'b1;
    end
    chk("rstm_no_rvalid", seen, 0);

    // Back-to-back host writes with host_valid held high.
    base = wren_cnt;
    for (int i = 0; i < 3; i++) begin
      pb = 8'h30 + 8'(i);
      host_req(1, 14'(8 + i), {32{pb}}, '1); settle();
      chk("b2b_ready", host_ready, 1);
      tick(); settle();
      chk("b2b_wren", wren, 1);
      chk("b2b_addr", ip_address, 14'(8 + i));
      chk("b2b_data", writeData, {32{pb}});
      chk("b2b_ready_drop", host_ready, 0);
      tick();
    end
    host_idle(); tick(); settle();
    chk("b2b_count", 32'(wren_cnt - base), 3);
    chk("b2b_mem9", mem[9], {32{8'h31}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the vector load/store unit (VLSU) and a host loader port used for image upload and readback. The arbiter sits directly downstream of the VLSU, between it and the `dmem` RAM. The VLSU keeps absolute priority and sees a fixed-latency RAM with no stalls. Host requests are buffered in one holding register and issued only in cycles when the VLSU drives neither `rden` nor `wren`.

## Interface
- `ADDR_W`, 14: dmem line address width.
- `DATA_W`, 256: line width in bits.
- `BE_W`, 32: byte-enable width (`DATA_W/8`).
- `READ_LATENCY`, 1: cycles from `rden` to valid `readData` at dmem. Must be ≥1.
- `STARVE_LIMIT`, 64: pending-wait cycles after which `host_starved` is raised.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-low.
- `vlsu_rden`, `vlsu_wren`, in, 1 each: VLSU read/write strobes.
- `vlsu_address`, in, ADDR_W: VLSU line address.
- `vlsu_byteena`, in, BE_W: VLSU byte enables.
- `vlsu_writeData`, in, DATA_W: VLSU write data.
- `vlsu_readData`, out, DATA_W: combinational pass-through of `readData`.
- `host_valid`, in, 1: host request valid.
- `host_ready`, out, 1: holding register empty; request accepted when `host_valid && host_ready`.
- `host_we`, in, 1: 1 = write, 0 = read.
- `host_address`, in, ADDR_W: host line address.
- `host_byteena`, in, BE_W: host byte enables (writes only).
- `host_writeData`, in, DATA_W: host write data.
- `host_rvalid`, out, 1: one-cycle pulse; `host_readData` is valid.
- `host_readData`, out, DATA_W: registered host read result.
- `host_starved`, out, 1: a pending host request has waited `STARVE_LIMIT` cycles.
- `rden`, `wren`, out, 1 each: dmem strobes.
- `ip_address`, out, ADDR_W: dmem address.
- `byteena`, out, BE_W: dmem byte enables.
- `writeData`, out, DATA_W: dmem write data.
- `readData`, in, DATA_W: dmem read data.

## Operation
- States:
  - IDLE: `host_ready`=1.
  - PENDING: request latched, waiting for a free slot.
  - RD_WAIT: host read in flight.
  - RESP: `host_rvalid` pulse.
- VLSU active means `vlsu_rden | vlsu_wren`.
- dmem outputs:
  - If state is PENDING and the VLSU is idle, the dmem outputs carry the host request (host issue cycle).
  - Otherwise the dmem outputs carry the VLSU signals unchanged (combinational mux).
- IDLE → PENDING on handshake. There is no same-cycle bypass; a host request is issued one cycle after acceptance at the earliest.
- From PENDING on an issue cycle:
  - Write: drive `wren`=1 with `host_byteena`, then go to IDLE.
  - Read: drive `rden`=1 with `byteena`=all ones, then go to RD_WAIT.
- From PENDING with the VLSU active: stay in PENDING and increment the starve counter. The counter saturates at `STARVE_LIMIT`.
- `host_starved` = (counter == `STARVE_LIMIT`). The counter clears on issue. The flag is informational; the hazard unit may insert a bubble in response.
- RD_WAIT:
  - Counts `READ_LATENCY` cycles.
  - In the cycle `readData` is valid, it is captured into `host_readData`, then the state moves to RESP.
  - VLSU accesses during RD_WAIT pass through normally. The single port serialises accesses, so return data never collide.
- RESP: `host_rvalid`=1 for exactly one cycle, then IDLE. `host_ready`=0 in RESP.
- `vlsu_readData` is always `readData`. The VLSU ignores cycles it did not request.
- Reset (`reset`=0 at a rising edge):
  - State → IDLE; holding register and counter cleared.
  - `host_rvalid`=0, `host_readData`=0, `host_starved`=0, `host_ready`=1 from the next cycle.
  - An in-flight host read is discarded.
  - dmem outputs follow the VLSU (0 when the VLSU is idle).

## Timing
- Host read, VLSU idle:
  - Accept at cycle T.
  - Issue at T+1.
  - `readData` valid at T+1+`READ_LATENCY`.
  - `host_rvalid` at T+2+`READ_LATENCY`.
  - Minimum request-to-request interval: `READ_LATENCY`+3 cycles.
- Host write, VLSU idle: accept at T, write at T+1, `host_ready` at T+2.
- VLSU latency is unchanged: zero added cycles, combinational path only.
- `host_rvalid` never asserts for a write. At most one host transaction is outstanding.

## Structure
- Package `dmem_arb_pkg`:
  - State enum (IDLE, PENDING, RD_WAIT, RESP).
  - Default width constants (14/256/32).
  - Holding-register struct {we, address, byteena, writeData}.
- One sub-module, `rd_latency_pipe`: a `READ_LATENCY`-deep valid shift register that flags the `readData` capture cycle.

## Test plan
- Host write, VLSU idle: addr 5, data 256'hA5…A5, byteena all ones → `wren`=1 and `ip_address`=5 exactly one cycle after acceptance. A following host read of addr 5 returns 256'hA5…A5 with a `host_rvalid` pulse at T+3 (`READ_LATENCY`=1).
- VLSU priority: VLSU drives a 2-line unaligned store (addr 0, then 1) while a host read is pending → dmem sees VLSU ops in those cycles and the host read issues in the first idle cycle after. VLSU data is unchanged.
- Interleave: host read in RD_WAIT while the VLSU reads addr 2 on the next cycle → `host_readData` holds the host line and the VLSU receives the addr-2 line one cycle later. There is no cross-contamination.
- Starvation: `STARVE_LIMIT`=4, VLSU continuously active for 10 cycles with a host request pending → `host_starved` rises after 4 wait cycles, stays high, and clears on the issue cycle.
- Reset mid-operation: `reset`=0 while in RD_WAIT → `host_rvalid` never pulses, `host_ready`=1 the next cycle, and dmem strobes are 0.
- Back-to-back: `host_valid` held high for 3 writes → `host_ready` drops after each acceptance, and exactly 3 `wren` pulses occur at addresses in request order.
